fp_to_int_pipelined: RTL

Three-stage pipelined converter from the team's single-precision `float_point_num` format (`sign`, `exp[7:0]`, `mant[22:0]`, from `float_types_pkg`) to a signed 32-bit integer. It is the consuming end of the FPU datapath. It accepts the `answer_o`/`vld_i`-style stream produced by `pipilined_fp_summator` and returns fixed-point results to integer logic, with a 2-bit status in the same style as `num_status_o`. It accepts one operand per cycle, has no backpressure, and has a fixed latency.

---
 rtl/fp_to_int_pipelined.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fp_to_int_pipelined.sv
// fp_to_int_pipelined: 3-stage float -> int32 converter (unpack, align, round).
// Define FP2INT_ROUND_NEAREST_EN for round-to-nearest-even, else truncate.

package float_types_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_point_num;

  typedef struct packed {
    logic        sign;
    logic [23:0] sig;
    logic [8:0]  e;
    logic        zero;
    logic        nan;
    logic        sat;
    logic        min_int;
    logic        mant_nz;
  } f2i_s1_t;

  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
    logic        g;
    logic        r;
    logic        s;
    logic        nan;
    logic        sat;
    logic        min_int;
  } f2i_s2_t;

endpackage

module fp_to_int_pipelined
  import float_types_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  float_point_num        a_i,
  input  logic                  vld_i,
  output logic signed [31:0]    int_o,
  output logic                  vld_o,
  output logic [1:0]            num_status_o
);

  f2i_s1_t s1_d, s1_q;
  f2i_s2_t s2_d, s2_q;
  logic    s1_vld, s2_vld;

  logic [31:0] int_d;
  logic [1:0]  st_d;

  // Stage 1: unpack and classify
  always_comb begin
    s1_d         = '0;
    s1_d.sign    = a_i.sign;
    s1_d.zero    = (a_i.exp == 8'd0);
    s1_d.sig     = s1_d.zero ? 24'd0 : {1'b1, a_i.mant};
    s1_d.e       = {1'b0, a_i.exp} - 9'd127;
    s1_d.mant_nz = |a_i.mant;
    s1_d.nan     = (&a_i.exp) && (|a_i.mant);
    s1_d.sat     = ((&a_i.exp) && !(|a_i.mant)) ||
                   ($signed(s1_d.e) >= 9'sd31);
    s1_d.min_int = a_i.sign && (a_i.exp == 8'd158) &&
                   !(|a_i.mant);
  end

  // Stage 2: align
  logic signed [8:0] e_s;
  logic [2:0]        lsh;
  logic [4:0]        rsh;
  logic [47:0]       wide;

  assign e_s  = s1_q.e;
  assign lsh  = s1_q.e[2:0] - 3'd7;
  assign rsh  = 5'd23 - s1_q.e[4:0];
  assign wide = {s1_q.sig, 24'd0} >> rsh;

  always_comb begin
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.nan     = s1_q.nan;
    s2_d.sat     = s1_q.sat;
    s2_d.min_int = s1_q.min_int;
    unique case (1'b1)
      s1_q.zero: begin
        s2_d.s = s1_q.mant_nz;
      end
      (e_s >= 9'sd23 && e_s <= 9'sd30): begin
        s2_d.mag = {8'd0, s1_q.sig} << lsh;
      end
      (e_s >= 9'sd0 && e_s <= 9'sd22): begin
        s2_d.mag = {8'd0, wide[47:24]};
        s2_d.g   = wide[23];
        s2_d.r   = wide[22];
        s2_d.s   = |wide[21:0];
      end
      (e_s == -9'sd1): begin
        s2_d.g = 1'b1;
        s2_d.s = s1_q.mant_nz;
      end
      default: begin
        s2_d.s = 1'b1;
      end
    endcase
  end

  // Stage 3: round, sign, saturate
  logic [32:0] mag_r;
  logic        inexact;
  logic        ovf;
  logic [31:0] res;

`ifdef FP2INT_ROUND_NEAREST_EN
  logic inc;
  assign inc   = s2_q.g & (s2_q.r | s2_q.s | s2_q.mag[0]);
  assign mag_r = {1'b0, s2_q.mag} + {32'd0, inc};
`else
  assign mag_r = {1'b0, s2_q.mag};
`endif

  assign inexact = s2_q.g | s2_q.r | s2_q.s;
  assign ovf     = s2_q.sign ? (mag_r > 33'h0_8000_0000)
                             : (mag_r > 33'h0_7FFF_FFFF);
  assign res     = s2_q.sign ? (32'd0 - mag_r[31:0])
                             : mag_r[31:0];

  always_comb begin
    int_d = res;
    st_d  = {1'b0, inexact};
    if (s2_q.nan) begin
      int_d = 32'h0000_0000;
      st_d  = 2'b11;
    end else if (s2_q.min_int) begin
      int_d = 32'h8000_0000;
      st_d  = 2'b00;
    end else if (s2_q.sat || ovf) begin
      int_d = s2_q.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
      st_d  = 2'b10;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_vld       <= 1'b0;
      s2_vld       <= 1'b0;
      s1_q         <= '0;
      s2_q         <= '0;
      vld_o        <= 1'b0;
      int_o        <= '0;
      num_status_o <= 2'b00;
    end else begin
      s1_vld       <= vld_i;
      s1_q         <= s1_d;
      s2_vld       <= s1_vld;
      s2_q         <= s2_d;
      vld_o        <= s2_vld;
      int_o        <= int_d;
      num_status_o <= st_d;
    end
  end

endmodule
